// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, word/state transforms,
// round constants and the decryptor FSM encoding.
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEXP, ROUND, FINAL, DONE} state_t;

  // Index 0 and 11..15 are never used; padding keeps a 4-bit index in range.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (rk_i -> rk_i+1) or backward
// (rk_i -> rk_i-1); both directions share a single SubWord.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  input  logic         dir,
  output logic [127:0] rk_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] b1, b2, b3;
  logic [31:0] sw, t0;

  assign {w0, w1, w2, w3} = rk_in;

  assign b3 = w3 ^ w2;
  assign b2 = w2 ^ w1;
  assign b1 = w1 ^ w0;

  // Forward mixes the old w3, backward the recovered previous w3.
  assign sw = sub_word(rot_word(dir ? b3 : w3));
  assign t0 = w0 ^ sw ^ {rcon, 24'h000000};

  always_comb begin
    if (dir) rk_out = {t0, b1, b2, b3};
    else     rk_out = {t0, w1 ^ t0, w2 ^ w1 ^ t0, w3 ^ w2 ^ w1 ^ t0};
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one round per clock, round keys derived on the
// fly (forward to rk10, then backward), optional one-entry rk10 cache.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  state_t       state, state_nxt;
  logic [127:0] st, rk, kreg;
  logic [127:0] cache_key, cache_rk;
  logic         cache_valid;
  logic [3:0]   cnt;  // KEXP step 1..10, then ROUND index 10..1

  logic [127:0] rk_step, t, rnd_in, rnd_out;
  logic         cache_hit;

  assign cache_hit = KEY_CACHE && cache_valid && (key == cache_key);

  aes_key_step u_key_step (
    .rk_in  (rk),
    .rcon   (RCON[cnt]),
    .dir    (state == ROUND),
    .rk_out (rk_step)
  );

  // The first inverse round has no InvMixColumns.
  assign t       = st ^ rk;
  assign rnd_in  = (cnt == 4'd10) ? t : inv_mix_columns(t);
  assign rnd_out = inv_sub_bytes(inv_shift_rows(rnd_in));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = cache_hit ? ROUND : KEXP;
      end
      KEXP:    if (cnt == 4'd10) state_nxt = ROUND;
      ROUND:   if (cnt == 4'd1)  state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= '0;
      rk          <= '0;
      kreg        <= '0;
      cnt         <= '0;
      cache_key   <= '0;
      cache_rk    <= '0;
      cache_valid <= 1'b0;
      plaintext   <= '0;
      out_valid   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          st   <= ciphertext;
          kreg <= key;
          if (cache_hit) begin
            rk  <= cache_rk;
            cnt <= 4'd10;
          end else begin
            rk  <= key;
            cnt <= 4'd1;
          end
        end
        KEXP: begin
          rk <= rk_step;
          if (cnt == 4'd10) begin
            if (KEY_CACHE) begin
              cache_key   <= kreg;
              cache_rk    <= rk_step;
              cache_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          st  <= rnd_out;
          rk  <= rk_step;
          cnt <= cnt - 4'd1;
        end
        FINAL: begin
          plaintext <= st ^ rk;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Walking the schedule back must land exactly on the cipher key.
  a_rk0_matches_key: assert property (@(posedge clk) disable iff (rst)
    (state == FINAL) |-> (rk == kreg));

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 vectors, cache hit/miss latency,
// backpressure, mid-block reset, and a random encrypt/decrypt round-trip.
`timescale 1ns/1ps
module tb_aes_decrypt_iter;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst, use_nc;
  logic         in_valid, out_ready;
  logic [127:0] ciphertext, key;
  logic         m_in_valid, m_out_ready, m_in_ready, m_out_valid;
  logic         n_in_valid, n_out_ready, n_in_ready, n_out_valid;
  logic [127:0] m_pt, n_pt;
  logic         in_ready, out_valid;
  logic [127:0] plaintext;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Shared stimulus is steered to one core at a time.
  assign m_in_valid  = in_valid  & ~use_nc;
  assign m_out_ready = out_ready & ~use_nc;
  assign n_in_valid  = in_valid  &  use_nc;
  assign n_out_ready = out_ready &  use_nc;
  assign in_ready    = use_nc ? n_in_ready  : m_in_ready;
  assign out_valid   = use_nc ? n_out_valid : m_out_valid;
  assign plaintext   = use_nc ? n_pt        : m_pt;

  aes_decrypt_iter #(.KEY_CACHE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .ciphertext(ciphertext), .key(key), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .plaintext(m_pt));

  aes_decrypt_iter #(.KEY_CACHE(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .ciphertext(ciphertext), .key(key), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .plaintext(n_pt));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent forward cipher used to produce round-trip ciphertexts.
  function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, o, rk;
    logic [31:0]  w0, w1, w2, w3;
    logic [7:0]   a0, a1, a2, a3;
    rk = k;
    s  = p ^ rk;
    for (int r = 1; r <= 10; r++) begin
      o = '0;
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          o[127-8*(4*c+row) -: 8] = sbox(s[127-8*(4*((c+row)%4)+row) -: 8]);
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = o[127-32*c -: 32];
          o[127-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
      end
      {w0, w1, w2, w3} = rk;
      w0 = w0 ^ sub_word(rot_word(w3)) ^ {RCON[r], 24'h0};
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rk = {w0, w1, w2, w3};
      s  = o ^ rk;
    end
    return s;
  endfunction

  task automatic start_block(input logic [127:0] k, input logic [127:0] ct);
    int n;
    @(negedge clk);
    key        = k;
    ciphertext = ct;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    key        = ~k;
    ciphertext = ~ct;
  endtask

  // Counts clock edges from the accept edge to out_valid rising (bounded).
  task automatic wait_out(input bit chk_rk, input logic [127:0] exp_rk, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (chk_rk && lat == 10) check("rk10_after_kexp", dut.rk, exp_rk);
    end
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", 128'(out_valid), 128'd0);
    check("in_ready_back", 128'(in_ready), 128'd1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input int exp_lat);
    int lat;
    start_block(k, ct);
    wait_out(1'b0, '0, lat);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_pt"}, plaintext, exp_pt);
    release_out();
  endtask

  initial begin
    int           lat;
    bit           stable;
    logic [127:0] hold_pt, kk, pp, prev_key;

    rst = 1'b1; use_nc = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    key = '0; ciphertext = '0;
    #1;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_pt", plaintext, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 C.1 (miss), then B with rk10 probe and scrambled inputs after accept.
    run_block("c1_miss", C1_KEY, C1_CT, C1_PT, 21);
    start_block(B_KEY, B_CT);
    wait_out(1'b1, B_RK10, lat);
    check("b_miss_latency", 128'(lat), 128'd21);
    check("b_miss_pt", plaintext, B_PT);
    release_out();

    run_block("b_hit", B_KEY, B_CT, B_PT, 11);
    run_block("c1_after_b", C1_KEY, C1_CT, C1_PT, 21);

    // Backpressure: hold for 50 cycles while offering a competing block.
    start_block(C1_KEY, C1_CT);
    wait_out(1'b0, '0, lat);
    check("bp_latency", 128'(lat), 128'd11);
    hold_pt = plaintext;
    stable  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 20) begin key = B_KEY; ciphertext = B_CT; in_valid = 1'b1; end
      if (i == 22) in_valid = 1'b0;
      if (!out_valid || plaintext !== hold_pt || in_ready) stable = 1'b0;
    end
    check("bp_stable", 128'(stable), 128'd1);
    check("bp_pt", plaintext, C1_PT);
    release_out();
    repeat (25) @(negedge clk);
    check("bp_pulse_ignored", 128'(out_valid), 128'd0);

    // Mid-block reset during ROUND r=5 of a cache hit; cache must be dropped.
    run_block("b_refill", B_KEY, B_CT, B_PT, 21);
    start_block(B_KEY, B_CT);
    repeat (5) @(posedge clk);
    #1;
    check("rst_at_round5", 128'(dut.cnt), 128'd5);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_cache_valid", 128'(dut.cache_valid), 128'd0);
    run_block("b_after_rst", B_KEY, B_CT, B_PT, 21);

    // Uncached variant: a repeated key still pays full expansion.
    use_nc = 1'b1;
    run_block("nc_first", B_KEY, B_CT, B_PT, 21);
    run_block("nc_repeat", B_KEY, B_CT, B_PT, 21);
    use_nc = 1'b0;

    // Round-trip against the bench cipher with random gaps and key reuse.
    check("model_fips_b", encrypt(B_KEY, B_PT), B_CT);
    prev_key = B_KEY;
    for (int i = 0; i < 1000; i++) begin
      kk = (i % 3 == 1) ? prev_key : {$urandom, $urandom, $urandom, $urandom};
      pp = {$urandom, $urandom, $urandom, $urandom};
      prev_key = kk;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_block(kk, encrypt(kk, pp));
      wait_out(1'b0, '0, lat);
      check("rt_pt", plaintext, pp);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_iter.md
Name: aes_decrypt_iter

Overview:
- Iterative AES-128 decryption core: one round per clock, valid/ready handshake on input and output.
- Inverse of the AES-128 encrypt datapath; a ciphertext produced by the encryptor from the same key decrypts back to the original plaintext.
- Byte ordering is FIPS-197: bits [127:120] = byte 0, column-major state, identical to the encryptor.
- Round keys are generated on the fly: forward expansion to round key 10, then backward derivation during the rounds. An optional one-entry cache skips the forward expansion when the key repeats.

Parameters:
- KEY_CACHE, 1: 1 = keep the last key and its round key 10, and skip the forward expansion on a matching key; 0 = always expand.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: ciphertext and key are valid.
- in_ready, output, 1: core accepts a block; high only in IDLE.
- ciphertext, input, 128: block to decrypt.
- key, input, 128: AES-128 cipher key (round key 0).
- out_valid, output, 1: plaintext is valid; held until accepted.
- out_ready, input, 1: downstream accepts plaintext.
- plaintext, output, 128: decrypted block, registered.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE. in_ready=1 after release, out_valid=0, plaintext=0.
  - Internal state and round-key registers are cleared; cache_valid=0.
  - Reset asserted mid-operation aborts the block with no output.
- FSM states: IDLE, KEXP, ROUND, FINAL, DONE.
- IDLE, accept edge (in_valid & in_ready):
  - Latch ciphertext into st and key into kreg.
  - Cache hit (KEY_CACHE=1, cache_valid, key == cached key): rk <= cached rk10, r <= 10, go to ROUND.
  - Otherwise: rk <= key, cnt <= 1, go to KEXP.
- KEXP, 10 cycles, cnt = 1..10:
  - rk <= fwd_step(rk, rcon[cnt]), where w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon and wi' = wi ^ w(i-1)'.
  - After cnt=10: rk = round key 10. Go to ROUND with r=10.
  - If KEY_CACHE=1, also load the cache with kreg and rk10, and set cache_valid=1.
- ROUND, 10 cycles, r = 10 down to 1:
  - t = st ^ rk.
  - r=10: st <= InvSubBytes(InvShiftRows(t)).
  - r<10: st <= InvSubBytes(InvShiftRows(InvMixColumns(t))).
  - Every cycle: rk <= bwd_step(rk, rcon[r]), where w3' = w3 ^ w2, w2' = w2 ^ w1, w1' = w1 ^ w0, w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon.
  - After r=1: rk = round key 0, which must equal kreg (assertion).
- FINAL, 1 cycle: plaintext <= st ^ rk, out_valid <= 1, go to DONE.
- DONE: outputs held stable. On out_ready: out_valid <= 0, go to IDLE. out_ready while out_valid=0 is ignored.
- Latency, accept edge to out_valid rising edge: 21 cycles on a miss, 11 cycles on a cache hit.
- Throughput: one block per latency + 1 + handshake cycles. There is no overlap; in_ready=0 in every state except IDLE.
- Input changes after acceptance have no effect. in_valid dropping mid-block is ignored.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- GF(2^8) reduction polynomial 0x11b. InvMixColumns coefficients 0e,0b,0d,09.

Decomposition:
- Package aes_pkg holds:
  - functions sbox, inv_sbox, xtime, gmul;
  - functions sub_word, rot_word, inv_shift_rows, inv_mix_columns;
  - the rcon constant array;
  - the FSM state enum.
- The encryptor reuses sbox, sub_word and rcon from the same package.
- One sub-module, aes_key_step: combinational, ports rk_in, rcon, dir (0 = forward, 1 = backward), rk_out. A single instance serves both KEXP and ROUND.
- The round datapath stays inline in aes_decrypt_iter.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff; out_valid rises exactly 21 cycles after accept.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734. Internal rk after KEXP = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Cache hit: repeat the B vector back-to-back with KEY_CACHE=1 -> same pt, latency 11. Then send the C.1 key -> latency 21 with the correct pt. With KEY_CACHE=0, every block takes 21.
- Backpressure: hold out_ready=0 for 50 cycles -> out_valid and plaintext stable, in_ready=0. The in_valid pulse offered in that window is not accepted. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-block: assert rst at ROUND r=5 -> out_valid=0 and in_ready=1 immediately after release, cache invalid. The next B vector takes 21 cycles and is correct.
- Round-trip: 1000 random key/pt pairs encrypted by the AES encrypt block, fed with random in_valid/out_ready gaps -> every pt recovered. Assertion: rk == kreg whenever in FINAL.
